switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 126 ++++++++++++
 tb/tb_switch_debouncer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Debounces NSW raw switches: 2-flop synchronizer, tick prescaler and an IDLE/COUNT commit FSM.
// Optional overrun flag is built only when SWDEB_OVERRUN_EN is defined; otherwise OVR is tied low.
module switch_debouncer #(
    parameter int NSW      = 10,
    parameter int TICK_DIV = 5000,
    parameter int STABLE_N = 10
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [NSW-1:0] SW,
    input  logic           ACK,
    output logic [NSW-1:0] SDATA,
    output logic           RDY,
    output logic           OVR
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_N + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [NSW-1:0] sw_meta_q, sw_s_q;
    logic [PW-1:0]  pre_q, pre_d;
    logic           tick;
    logic [0:0]     state_q, state_d;
    logic [NSW-1:0] cand_q, cand_d;
    logic [NSW-1:0] sdata_q, sdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rdy_q, rdy_d;
    logic           commit;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        sdata_d = sdata_q;
        commit  = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (sw_s_q != sdata_q) begin
                        if (STABLE_N == 1) begin
                            sdata_d = sw_s_q;
                            commit  = 1'b1;
                        end else begin
                            cand_d  = sw_s_q;
                            cnt_d   = CW'(1);
                            state_d = S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    // A return to the committed value is a bounce: abandon the candidate.
                    if (sw_s_q == sdata_q) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else if (sw_s_q != cand_q) begin
                        cand_d = sw_s_q;
                        cnt_d  = CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        sdata_d = cand_q;
                        commit  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A commit wins over a same-cycle ACK so the new value is never lost.
    assign rdy_d = commit | (rdy_q & ~ACK);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
            pre_q     <= '0;
            state_q   <= S_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            sdata_q   <= '0;
            rdy_q     <= 1'b0;
        end else begin
            sw_meta_q <= SW;
            sw_s_q    <= sw_meta_q;
            pre_q     <= pre_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            sdata_q   <= sdata_d;
            rdy_q     <= rdy_d;
        end
    end

`ifdef SWDEB_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Overrun: a fresh commit lands while the previous one is still unread.
    assign ovr_d = ACK ? 1'b0 : (ovr_q | (commit & rdy_q));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign OVR = ovr_q;
`else
    assign OVR = 1'b0;
`endif

    assign SDATA = sdata_q;
    assign RDY   = rdy_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized and directed bench for switch_debouncer against a sample-history reference model.
// Expects OVR behaviour matching whether SWDEB_OVERRUN_EN is defined for the build.
module tb_switch_debouncer;

    localparam int NSW = 10;
    localparam int TD  = 4;
    localparam int SN  = 3;
`ifdef SWDEB_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic           CLK;
    logic           RESET;
    logic [NSW-1:0] SW;
    logic           ACK;
    logic [NSW-1:0] SDATA;
    logic           RDY;
    logic           OVR;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [NSW-1:0] m_sync0 = '0;
    logic [NSW-1:0] m_sync1 = '0;
    logic [NSW-1:0] m_sdata = '0;
    bit             m_rdy = 1'b0;
    bit             m_ovr = 1'b0;
    int             m_n = 0;
    logic [NSW-1:0] hist[$];

    switch_debouncer #(.NSW(NSW), .TICK_DIV(TD), .STABLE_N(SN)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .SW    (SW),
        .ACK   (ACK),
        .SDATA (SDATA),
        .RDY   (RDY),
        .OVR   (OVR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Length of the trailing run of identical tick samples.
    function automatic int run_len();
        int r;
        r = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size()-1]) r++;
            else break;
        end
        return r;
    endfunction

    // True when the coming clock edge will commit a new value.
    function automatic bit m_commit_next();
        int r;
        if ((m_n % TD) != TD - 1 || m_sync1 == m_sdata) return 1'b0;
        r = (hist.size() > 0 && hist[hist.size()-1] == m_sync1) ? run_len() : 0;
        return (r + 1 >= SN);
    endfunction

    task automatic model_edge();
        logic [NSW-1:0] s;
        bit tk, cm;
        if (RESET) begin
            m_sync0 = '0; m_sync1 = '0; m_sdata = '0;
            m_rdy = 1'b0; m_ovr = 1'b0; m_n = 0;
            hist.delete();
        end else begin
            s  = m_sync1;
            tk = ((m_n % TD) == TD - 1);
            m_n++;
            cm = 1'b0;
            if (tk) begin
                hist.push_back(s);
                if (hist.size() > SN) void'(hist.pop_front());
                if (run_len() >= SN && s != m_sdata) cm = 1'b1;
            end
            if (OVR_EN) begin
                if (ACK) m_ovr = 1'b0;
                else if (cm && m_rdy) m_ovr = 1'b1;
            end
            m_rdy = cm | (m_rdy & !ACK);
            if (cm) m_sdata = s;
            m_sync1 = m_sync0;
            m_sync0 = SW;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check("sdata", 32'(SDATA), 32'(m_sdata));
        check("rdy", 32'(RDY), 32'(m_rdy));
        check("ovr", 32'(OVR), 32'(m_ovr));
    endtask

    task automatic wait_sdata(input string tag, input logic [NSW-1:0] tgt, input int maxc,
                              output int used);
        used = 0;
        while (SDATA !== tgt && used < maxc) begin
            step();
            used++;
        end
        check(tag, 32'(SDATA), 32'(tgt));
    endtask

    task automatic ack_pulse();
        ACK = 1'b1;
        step();
        ACK = 1'b0;
    endtask

    initial begin
        int used;
        bit found;
        RESET = 1'b1; SW = '0; ACK = 1'b0;
        repeat (3) step();
        check("rst_sdata", 32'(SDATA), 32'h0);
        check("rst_rdy", 32'(RDY), 32'h0);
        check("rst_ovr", 32'(OVR), 32'h0);
        RESET = 1'b0;

        // Quiet input
        repeat (100) step();
        check("quiet_sdata", 32'(SDATA), 32'h0);
        check("quiet_rdy", 32'(RDY), 32'h0);

        // Toggle every tick period: must never commit
        for (int i = 0; i < 40; i++) begin
            if (i % TD == 0) SW = (SW == 10'h005) ? 10'h000 : 10'h005;
            step();
        end
        SW = 10'h000;
        repeat (30) step();
        check("bounce_sdata", 32'(SDATA), 32'h0);
        check("bounce_rdy", 32'(RDY), 32'h0);

        // Clean step and worst-case latency
        SW = 10'h005;
        wait_sdata("step_sdata", 10'h005, 20, used);
        check("step_latency_ok", 32'(used <= 2 + TD * SN), 32'h1);
        check("step_rdy", 32'(RDY), 32'h1);
        ack_pulse();
        check("step_ack_clr", 32'(RDY), 32'h0);

        // ACK on the exact commit cycle
        SW = 10'h000;
        wait_sdata("back0_sdata", 10'h000, 20, used);
        ack_pulse();
        SW = 10'h005;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_commit_next()) found = 1'b1;
            else step();
        end
        check("ack_commit_found", 32'(found), 32'h1);
        ack_pulse();
        check("ack_commit_sdata", 32'(SDATA), 32'h005);
        check("ack_commit_rdy", 32'(RDY), 32'h1);
        ack_pulse();
        check("ack_second_clr", 32'(RDY), 32'h0);

        // Overrun: two commits without ACK
        SW = 10'h000;
        wait_sdata("ovr_pre0", 10'h000, 20, used);
        ack_pulse();
        SW = 10'h005;
        wait_sdata("ovr_c5", 10'h005, 20, used);
        check("ovr_first_clear", 32'(OVR), 32'h0);
        SW = 10'h00A;
        wait_sdata("ovr_cA", 10'h00A, 20, used);
        check("ovr_set", 32'(OVR), 32'(OVR_EN));
        check("ovr_rdy", 32'(RDY), 32'h1);
        ack_pulse();
        check("ovr_ack_rdy", 32'(RDY), 32'h0);
        check("ovr_ack_ovr", 32'(OVR), 32'h0);

        // Reset mid-count (cnt == 2), then re-debounce after reset
        SW = 10'h3FF;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (hist.size() > 0 && hist[hist.size()-1] == 10'h3FF && run_len() == 2 &&
                m_sdata != 10'h3FF) found = 1'b1;
            else step();
        end
        check("midcount_found", 32'(found), 32'h1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("midrst_sdata", 32'(SDATA), 32'h0);
        check("midrst_rdy", 32'(RDY), 32'h0);
        check("midrst_ovr", 32'(OVR), 32'h0);
        wait_sdata("postrst_sdata", 10'h3FF, 20, used);
        check("postrst_rdy", 32'(RDY), 32'h1);
        ack_pulse();

        // Randomized traffic with bursts of bouncing and quiet stretches
        for (int i = 0; i < 1500; i++) begin
            if ((i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0))
                SW = ($urandom_range(0, 1) == 0) ? 10'($urandom)
                                                 : (SW ^ (10'd1 << $urandom_range(0, 9)));
            ACK   = ($urandom_range(0, 15) == 0);
            RESET = ($urandom_range(0, 299) == 0);
            step();
        end
        ACK = 1'b0;
        RESET = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
